// File: rtl/disposition_seq_pkg.sv
// Shared types for the disposition sequencer: the incoming disposition word,
// the conditional encoding, the result/command record, FSM states and the
// watchdog limit used when DISP_SEQ_TIMEOUT_EN is defined.
package disposition_seq_pkg;

    localparam int U64_ADDRESS_SIZE = 16;
    localparam int ADDR_W           = U64_ADDRESS_SIZE;
    localparam int DATA_W           = 64;
    localparam int FLAG_W           = 8;
    localparam int CTX_W            = 4;
    localparam int FLAG_IDX_W       = $clog2(FLAG_W);
    localparam int INFO_W           = 8;
    localparam int ID_W             = 8;

    // Positions of the seven conditionals inside the take vector.
    localparam int NUM_COND    = 7;
    localparam int TAKE_EXEC   = 0;
    localparam int TAKE_FORK   = 1;
    localparam int TAKE_DELETE = 2;
    localparam int TAKE_SLEEP  = 3;
    localparam int TAKE_SELF   = 4;
    localparam int TAKE_OTHER  = 5;
    localparam int TAKE_WRITE  = 6;

    localparam int WDOG_W = 16;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF;

    // SimpleConditional: never / always / when flag set / when flag clear.
    typedef enum logic [1:0] {
        COND_NEVER  = 2'd0,
        COND_ALWAYS = 2'd1,
        COND_IF_SET = 2'd2,
        COND_IF_CLR = 2'd3
    } cond_mode_e;

    typedef struct packed {
        cond_mode_e            mode;
        logic [FLAG_IDX_W-1:0] idx;
    } simple_cond_t;

    typedef struct packed {
        simple_cond_t      exec_c;
        logic [INFO_W-1:0] exec_info;
        logic [ID_W-1:0]   exec_id;
        simple_cond_t      fork_c;
        logic [INFO_W-1:0] fork_info;
        logic              fork_sleep;
        logic [ID_W-1:0]   fork_id;
        simple_cond_t      delete_c;
        simple_cond_t      sleep_c;
        simple_cond_t      self_read_c;
        logic [ADDR_W-1:0] self_read_address;
        simple_cond_t      read_other_c;
        logic [ADDR_W-1:0] read_other_who;
        logic [ADDR_W-1:0] read_other_where;
        simple_cond_t      write_c;
        logic [ADDR_W-1:0] write_address;
        logic              write_back;
    } disposition_a;

    typedef struct packed {
        logic [CTX_W-1:0]  ctx;
        logic              err;
        logic              del;
        logic              sleep;
        logic              exec_en;
        logic [INFO_W-1:0] exec_info;
        logic [ID_W-1:0]   exec_id;
        logic              fork_en;
        logic [INFO_W-1:0] fork_info;
        logic              fork_sleep;
        logic [ID_W-1:0]   fork_id;
        logic [DATA_W-1:0] self_data;
        logic [DATA_W-1:0] other_data;
    } disp_result_t;

    localparam int DISP_W = $bits(disposition_a);
    localparam int RES_W  = $bits(disp_result_t);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EVAL     = 3'd1,
        RD_SELF  = 3'd2,
        RD_OTHER = 3'd3,
        WRITE    = 3'd4,
        RESULT   = 3'd5
    } seq_state_e;

    // Evaluate one SimpleConditional against the context flags.
    function automatic logic simple_cond_eval(simple_cond_t c, logic [FLAG_W-1:0] flags);
        logic r;
        case (c.mode)
            COND_NEVER:  r = 1'b0;
            COND_ALWAYS: r = 1'b1;
            COND_IF_SET: r = flags[c.idx];
            COND_IF_CLR: r = ~flags[c.idx];
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/disposition_cond_eval.sv
// Combinational evaluation of the seven disposition conditionals into a
// take vector indexed by the TAKE_* positions.
module disposition_cond_eval
    import disposition_seq_pkg::*;
(
    input  simple_cond_t [NUM_COND-1:0] conds_i,
    input  logic [FLAG_W-1:0]           flags_i,
    output logic [NUM_COND-1:0]         take_o
);

    // Evaluate every conditional independently against the same flags.
    always_comb begin
        take_o = {NUM_COND{1'b0}};
        for (int i = 0; i < NUM_COND; i++) begin
            take_o[i] = simple_cond_eval(conds_i[i], flags_i);
        end
    end

endmodule

// File: rtl/disposition_sequencer.sv
// Disposition sequencer: captures one disposition word, resolves its
// conditionals, performs self read / other read / write over one EV data
// port, then presents a single command record to the context cache.
// Optional build macro DISP_SEQ_TIMEOUT_EN adds a 16-bit access watchdog
// and the err_o pulse port; without it err in the result is always 0.
module disposition_sequencer
    import disposition_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  logic [DISP_W-1:0] disp_i,
    input  logic [CTX_W-1:0]  ctx_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [CTX_W-1:0]  mem_ctx_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [RES_W-1:0]  res_o,
    output logic              busy_o
`ifdef DISP_SEQ_TIMEOUT_EN
    ,
    output logic              err_o
`endif
);

    seq_state_e           state_q, state_d;
    disposition_a         disp_q, disp_d;
    logic [CTX_W-1:0]     ctx_q, ctx_d;
    logic [FLAG_W-1:0]    flags_q, flags_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_COND-1:0]  take_q, take_d;
    logic [DATA_W-1:0]    self_data_q, self_data_d;
    logic [DATA_W-1:0]    other_data_q, other_data_d;
    logic                 granted_q, granted_d;
    logic                 err_q, err_d;

    logic                 disp_ready_q, disp_ready_d;
    logic                 busy_q, busy_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [CTX_W-1:0]     mem_ctx_q, mem_ctx_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 res_valid_q, res_valid_d;
    disp_result_t         res_q, res_d;
    logic                 err_pulse_q, err_pulse_d;

    disposition_a                disp_in_s;
    simple_cond_t [NUM_COND-1:0] conds_s;
    logic [NUM_COND-1:0]         take_s;
    logic                        rd_done_s;
    logic                        timeout_s;
    logic                        unused_who_s;

    assign disp_in_s    = disp_i;
    assign rd_done_s    = (granted_q | mem_gnt_i) & mem_rvalid_i;
    assign unused_who_s = ^disp_q.read_other_who[ADDR_W-1:CTX_W];

    // First taken access strictly after the current stage, else RESULT.
    function automatic seq_state_e next_access(seq_state_e cur, logic [NUM_COND-1:0] take);
        seq_state_e nxt;
        case (cur)
            EVAL: begin
                if (take[TAKE_SELF]) begin
                    nxt = RD_SELF;
                end else if (take[TAKE_OTHER]) begin
                    nxt = RD_OTHER;
                end else if (take[TAKE_WRITE]) begin
                    nxt = WRITE;
                end else begin
                    nxt = RESULT;
                end
            end
            RD_SELF: begin
                if (take[TAKE_OTHER]) begin
                    nxt = RD_OTHER;
                end else if (take[TAKE_WRITE]) begin
                    nxt = WRITE;
                end else begin
                    nxt = RESULT;
                end
            end
            RD_OTHER: begin
                if (take[TAKE_WRITE]) begin
                    nxt = WRITE;
                end else begin
                    nxt = RESULT;
                end
            end
            default: nxt = RESULT;
        endcase
        return nxt;
    endfunction

    // Gather the seven conditionals of the captured word in TAKE_* order.
    always_comb begin
        conds_s              = '0;
        conds_s[TAKE_EXEC]   = disp_q.exec_c;
        conds_s[TAKE_FORK]   = disp_q.fork_c;
        conds_s[TAKE_DELETE] = disp_q.delete_c;
        conds_s[TAKE_SLEEP]  = disp_q.sleep_c;
        conds_s[TAKE_SELF]   = disp_q.self_read_c;
        conds_s[TAKE_OTHER]  = disp_q.read_other_c;
        conds_s[TAKE_WRITE]  = disp_q.write_c;
    end

    disposition_cond_eval u_cond_eval (
        .conds_i (conds_s),
        .flags_i (flags_q),
        .take_o  (take_s)
    );

`ifdef DISP_SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              in_access_s;

    // Watchdog: counts idle cycles in an access state, restarts on any handshake.
    always_comb begin
        in_access_s = (state_q == RD_SELF) || (state_q == RD_OTHER) || (state_q == WRITE);
        timeout_s   = 1'b0;
        if (!in_access_s) begin
            wdog_d = {WDOG_W{1'b0}};
        end else if (mem_gnt_i || mem_rvalid_i) begin
            wdog_d = {WDOG_W{1'b0}};
        end else begin
            wdog_d    = wdog_q + 16'd1;
            timeout_s = (wdog_q == WDOG_LIMIT);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= {WDOG_W{1'b0}};
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign err_o = err_pulse_q;
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and captured-data logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        ctx_d        = ctx_q;
        flags_d      = flags_q;
        wdata_d      = wdata_q;
        take_d       = take_q;
        self_data_d  = self_data_q;
        other_data_d = other_data_q;
        granted_d    = granted_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (disp_valid_i) begin
                    disp_d       = disp_in_s;
                    ctx_d        = ctx_i;
                    flags_d      = flags_i;
                    wdata_d      = wdata_i;
                    take_d       = {NUM_COND{1'b0}};
                    self_data_d  = {DATA_W{1'b0}};
                    other_data_d = {DATA_W{1'b0}};
                    granted_d    = 1'b0;
                    err_d        = 1'b0;
                    state_d      = EVAL;
                end else begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                take_d  = take_s;
                state_d = next_access(EVAL, take_s);
            end
            RD_SELF: begin
                if (rd_done_s) begin
                    self_data_d = mem_rdata_i;
                    granted_d   = 1'b0;
                    state_d     = next_access(RD_SELF, take_q);
                end else if (mem_gnt_i) begin
                    granted_d = 1'b1;
                end else begin
                    granted_d = granted_q;
                end
            end
            RD_OTHER: begin
                if (rd_done_s) begin
                    other_data_d = mem_rdata_i;
                    granted_d    = 1'b0;
                    state_d      = next_access(RD_OTHER, take_q);
                end else if (mem_gnt_i) begin
                    granted_d = 1'b1;
                end else begin
                    granted_d = granted_q;
                end
            end
            WRITE: begin
                if (mem_gnt_i) begin
                    state_d = RESULT;
                end else begin
                    state_d = WRITE;
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESULT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_s) begin
            granted_d = 1'b0;
            err_d     = 1'b1;
            state_d   = RESULT;
        end else begin
            err_d = err_d;
        end
    end

    // Output values for the coming cycle, decoded from next state and data.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_ctx_d    = {CTX_W{1'b0}};
        mem_addr_d   = {ADDR_W{1'b0}};
        mem_wdata_d  = {DATA_W{1'b0}};
        res_valid_d  = 1'b0;
        res_d        = '0;
        disp_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        err_pulse_d  = timeout_s;
        case (state_d)
            RD_SELF: begin
                mem_req_d  = ~granted_d;
                mem_ctx_d  = ctx_d;
                mem_addr_d = disp_d.self_read_address;
            end
            RD_OTHER: begin
                mem_req_d  = ~granted_d;
                mem_ctx_d  = disp_d.read_other_who[CTX_W-1:0];
                mem_addr_d = disp_d.read_other_where;
            end
            WRITE: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_ctx_d   = ctx_d;
                mem_addr_d  = disp_d.write_address;
                mem_wdata_d = disp_d.write_back ? self_data_d : wdata_d;
            end
            RESULT: begin
                res_valid_d      = 1'b1;
                res_d.ctx        = ctx_d;
                res_d.err        = err_d;
                res_d.del        = take_d[TAKE_DELETE] & ~err_d;
                res_d.sleep      = take_d[TAKE_SLEEP] & ~err_d;
                res_d.exec_en    = take_d[TAKE_EXEC] & ~err_d;
                res_d.fork_en    = take_d[TAKE_FORK] & ~err_d;
                res_d.exec_info  = disp_d.exec_info;
                res_d.exec_id    = disp_d.exec_id;
                res_d.fork_info  = disp_d.fork_info;
                res_d.fork_sleep = disp_d.fork_sleep;
                res_d.fork_id    = disp_d.fork_id;
                res_d.self_data  = self_data_d;
                res_d.other_data = other_data_d;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // FSM state and captured word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            disp_q       <= '0;
            ctx_q        <= {CTX_W{1'b0}};
            flags_q      <= {FLAG_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            take_q       <= {NUM_COND{1'b0}};
            self_data_q  <= {DATA_W{1'b0}};
            other_data_q <= {DATA_W{1'b0}};
            granted_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            ctx_q        <= ctx_d;
            flags_q      <= flags_d;
            wdata_q      <= wdata_d;
            take_q       <= take_d;
            self_data_q  <= self_data_d;
            other_data_q <= other_data_d;
            granted_q    <= granted_d;
            err_q        <= err_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_ctx_q    <= {CTX_W{1'b0}};
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            disp_ready_q <= disp_ready_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_ctx_q    <= mem_ctx_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            res_valid_q  <= res_valid_d;
            res_q        <= res_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign disp_ready_o = disp_ready_q;
    assign busy_o       = busy_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_ctx_o    = mem_ctx_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign res_valid_o  = res_valid_q;
    assign res_o        = res_q;

endmodule

// File: tb/tb_disposition_sequencer.sv
// Directed bench for disposition_sequencer: a vector table exercising the
// conditional evaluation on no-access words, then hand-written sequences for
// reads, the full read/read/write chain, stalls, mid-operation reset and
// (when DISP_SEQ_TIMEOUT_EN is defined) the watchdog.
`timescale 1ns/1ps
module tb_disposition_sequencer;
    import disposition_seq_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              disp_valid_i;
    logic              disp_ready_o;
    logic [DISP_W-1:0] disp_i;
    logic [CTX_W-1:0]  ctx_i;
    logic [FLAG_W-1:0] flags_i;
    logic [DATA_W-1:0] wdata_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [CTX_W-1:0]  mem_ctx_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [RES_W-1:0]  res_o;
    logic              busy_o;
`ifdef DISP_SEQ_TIMEOUT_EN
    logic              err_o;
`endif

    disp_result_t r_s;
    assign r_s = res_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disposition_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .disp_valid_i (disp_valid_i),
        .disp_ready_o (disp_ready_o),
        .disp_i       (disp_i),
        .ctx_i        (ctx_i),
        .flags_i      (flags_i),
        .wdata_i      (wdata_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_ctx_o    (mem_ctx_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_o        (res_o),
        .busy_o       (busy_o)
`ifdef DISP_SEQ_TIMEOUT_EN
        ,
        .err_o        (err_o)
`endif
    );

    typedef struct {
        simple_cond_t ec;
        simple_cond_t fc;
        simple_cond_t dc;
        simple_cond_t sc;
        logic [7:0]   flags;
        logic [3:0]   ctx;
        logic [3:0]   exp_en;   // {delete, sleep, fork, exec}
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic simple_cond_t mk(input cond_mode_e m, input int idx);
        simple_cond_t c;
        c.mode = m;
        c.idx  = idx[FLAG_IDX_W-1:0];
        return c;
    endfunction

    task automatic send_word(input string nm, input disposition_a d, input logic [3:0] c,
                             input logic [7:0] f, input logic [63:0] w);
        int n;
        n = 0;
        while (!disp_ready_o && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_ready"}, 64'(disp_ready_o), 64'd1);
        disp_i       = d;
        ctx_i        = c;
        flags_i      = f;
        wdata_i      = w;
        disp_valid_i = 1'b1;
        tick();
        disp_valid_i = 1'b0;
        disp_i       = '0;
        wdata_i      = 64'd0;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!mem_req_o && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_req"}, 64'(mem_req_o), 64'd1);
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        while (!res_valid_o && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_res_valid"}, 64'(res_valid_o), 64'd1);
    endtask

    task automatic serve_read(input string nm, input logic [3:0] ectx, input logic [15:0] eaddr,
                              input logic [63:0] data, input int gnt_wait, input int rv_wait);
        int bad;
        bad = 0;
        wait_req(nm);
        check({nm, "_we"}, 64'(mem_we_o), 64'd0);
        check({nm, "_ctx"}, 64'(mem_ctx_o), 64'(ectx));
        check({nm, "_addr"}, 64'(mem_addr_o), 64'(eaddr));
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            if (mem_req_o !== 1'b1 || mem_addr_o !== eaddr || mem_ctx_o !== ectx) bad++;
        end
        check({nm, "_hold"}, 64'(bad), 64'd0);
        mem_gnt_i = 1'b1;
        if (rv_wait == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = data;
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
        end else begin
            tick();
            mem_gnt_i = 1'b0;
            check({nm, "_req_drop"}, 64'(mem_req_o), 64'd0);
            for (int i = 1; i < rv_wait; i++) tick();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = data;
            tick();
            mem_rvalid_i = 1'b0;
        end
        mem_rdata_i = 64'd0;
    endtask

    initial begin
        disposition_a d;
        disp_result_t held;
        logic [63:0]  w_addr, w_data;
        int           bad;

        vecs[0] = '{mk(COND_NEVER,0),  mk(COND_NEVER,0),  mk(COND_NEVER,0),  mk(COND_NEVER,0),  8'hFF, 4'd1, 4'b0000};
        vecs[1] = '{mk(COND_ALWAYS,0), mk(COND_ALWAYS,0), mk(COND_ALWAYS,0), mk(COND_ALWAYS,0), 8'h00, 4'd2, 4'b1111};
        vecs[2] = '{mk(COND_IF_SET,0), mk(COND_IF_CLR,0), mk(COND_IF_SET,7), mk(COND_IF_CLR,7), 8'h01, 4'd3, 4'b0101};
        vecs[3] = '{mk(COND_IF_SET,0), mk(COND_IF_CLR,0), mk(COND_IF_SET,7), mk(COND_IF_CLR,7), 8'h80, 4'd4, 4'b1010};
        vecs[4] = '{mk(COND_IF_SET,3), mk(COND_IF_SET,4), mk(COND_NEVER,0),  mk(COND_ALWAYS,0), 8'h18, 4'd5, 4'b0111};
        vecs[5] = '{mk(COND_IF_CLR,5), mk(COND_IF_SET,5), mk(COND_IF_CLR,2), mk(COND_IF_SET,6), 8'h40, 4'd15, 4'b1101};

        reset_n      = 1'b0;
        disp_valid_i = 1'b0;
        disp_i       = '0;
        ctx_i        = 4'd0;
        flags_i      = 8'd0;
        wdata_i      = 64'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'd0;
        res_ready_i  = 1'b1;
        tick();
        tick();
        check("rst_disp_ready", 64'(disp_ready_o), 64'd1);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        reset_n = 1'b1;
        tick();

        // Conditional table: no memory access, result 2 cycles after accept.
        for (int v = 0; v < 6; v++) begin
            d           = '0;
            d.exec_c    = vecs[v].ec;
            d.fork_c    = vecs[v].fc;
            d.delete_c  = vecs[v].dc;
            d.sleep_c   = vecs[v].sc;
            d.exec_info = 8'h10 + 8'(v);
            d.exec_id   = 8'h20 + 8'(v);
            d.fork_info = 8'h30 + 8'(v);
            d.fork_id   = 8'h40 + 8'(v);
            d.fork_sleep = v[0];
            send_word($sformatf("vec%0d", v), d, vecs[v].ctx, vecs[v].flags, 64'h55);
            check($sformatf("vec%0d_eval_busy", v), 64'(busy_o), 64'd1);
            check($sformatf("vec%0d_eval_nores", v), 64'(res_valid_o), 64'd0);
            tick();
            check($sformatf("vec%0d_res_valid", v), 64'(res_valid_o), 64'd1);
            check($sformatf("vec%0d_no_req", v), 64'(mem_req_o), 64'd0);
            check($sformatf("vec%0d_enables", v), 64'({r_s.del, r_s.sleep, r_s.fork_en, r_s.exec_en}),
                  64'(vecs[v].exp_en));
            check($sformatf("vec%0d_ctx", v), 64'(r_s.ctx), 64'(vecs[v].ctx));
            check($sformatf("vec%0d_pass", v), 64'({r_s.exec_info, r_s.exec_id, r_s.fork_info, r_s.fork_id, r_s.fork_sleep}),
                  64'({8'h10 + 8'(v), 8'h20 + 8'(v), 8'h30 + 8'(v), 8'h40 + 8'(v), v[0]}));
            check($sformatf("vec%0d_data0", v), r_s.self_data | r_s.other_data, 64'd0);
            tick();
            check($sformatf("vec%0d_back_idle", v), 64'(disp_ready_o), 64'd1);
        end

        // Single self read.
        d                   = '0;
        d.self_read_c       = mk(COND_ALWAYS, 0);
        d.self_read_address = 16'd3;
        d.exec_c            = mk(COND_ALWAYS, 0);
        send_word("self", d, 4'd5, 8'h00, 64'd0);
        serve_read("self_rd", 4'd5, 16'd3, 64'hDEAD_BEEF, 0, 2);
        wait_res("self");
        check("self_data", r_s.self_data, 64'hDEAD_BEEF);
        check("self_other0", r_s.other_data, 64'd0);
        check("self_exec", 64'(r_s.exec_en), 64'd1);
        check("self_ctx", 64'(r_s.ctx), 64'd5);
        check("self_noreq", 64'(mem_req_o), 64'd0);
        tick();

        // Full chain: self read -> other read -> write-back of self data.
        d                   = '0;
        d.self_read_c       = mk(COND_ALWAYS, 0);
        d.self_read_address = 16'd4;
        d.read_other_c      = mk(COND_IF_SET, 1);
        d.read_other_who    = 16'h00F2;
        d.read_other_where  = 16'd5;
        d.write_c           = mk(COND_IF_CLR, 6);
        d.write_address     = 16'd7;
        d.write_back        = 1'b1;
        d.exec_c            = mk(COND_IF_SET, 1);
        d.fork_c            = mk(COND_IF_CLR, 1);
        send_word("full", d, 4'd9, 8'h02, 64'h1111);
        serve_read("full_self", 4'd9, 16'd4, 64'hA5A5_0001_0000_1234, 2, 1);
        serve_read("full_other", 4'd2, 16'd5, 64'h5678, 0, 0);
        wait_req("full_wr");
        check("full_wr_we", 64'(mem_we_o), 64'd1);
        check("full_wr_ctx", 64'(mem_ctx_o), 64'd9);
        check("full_wr_addr", 64'(mem_addr_o), 64'd7);
        check("full_wr_data", mem_wdata_o, 64'hA5A5_0001_0000_1234);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        wait_res("full");
        check("full_self_data", r_s.self_data, 64'hA5A5_0001_0000_1234);
        check("full_other_data", r_s.other_data, 64'h5678);
        check("full_exec_fork", 64'({r_s.exec_en, r_s.fork_en}), 64'b10);
        tick();

        // Stalls: grant withheld 10 cycles, then consumer backpressure 5 cycles.
        d               = '0;
        d.write_c       = mk(COND_ALWAYS, 0);
        d.write_address = 16'h00AB;
        d.write_back    = 1'b0;
        d.delete_c      = mk(COND_ALWAYS, 0);
        d.sleep_c       = mk(COND_ALWAYS, 0);
        res_ready_i     = 1'b0;
        send_word("stall", d, 4'd3, 8'h00, 64'hCAFE);
        wait_req("stall_wr");
        w_addr = 64'(mem_addr_o);
        w_data = mem_wdata_o;
        check("stall_wr_addr", w_addr, 64'h00AB);
        check("stall_wr_data", w_data, 64'hCAFE);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || 64'(mem_addr_o) !== w_addr ||
                mem_wdata_o !== w_data || disp_ready_o !== 1'b0) bad++;
        end
        check("stall_req_stable", 64'(bad), 64'd0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        wait_res("stall");
        held = r_s;
        check("stall_del_sleep", 64'({r_s.del, r_s.sleep, r_s.exec_en, r_s.fork_en}), 64'b1100);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid_o !== 1'b1 || r_s !== held || disp_ready_o !== 1'b0) bad++;
        end
        check("stall_res_stable", 64'(bad), 64'd0);
        res_ready_i = 1'b1;
        tick();
        check("stall_released", 64'({res_valid_o, disp_ready_o}), 64'b01);

        // Reset while the other-read request is outstanding.
        d                  = '0;
        d.self_read_c      = mk(COND_ALWAYS, 0);
        d.self_read_address = 16'd1;
        d.read_other_c     = mk(COND_ALWAYS, 0);
        d.read_other_who   = 16'd6;
        d.read_other_where = 16'h0100;
        send_word("rst", d, 4'd1, 8'h00, 64'd0);
        serve_read("rst_self", 4'd1, 16'd1, 64'h77, 0, 1);
        wait_req("rst_other");
        check("rst_other_ctx", 64'(mem_ctx_o), 64'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({mem_req_o, res_valid_o, busy_o, disp_ready_o}), 64'b0001);
        check("midrst_addr", 64'(mem_addr_o), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hBAD;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'd0;
        tick();
        check("late_rvalid_ignored", 64'({res_valid_o, busy_o, mem_req_o, disp_ready_o}), 64'b0001);
        d        = '0;
        d.exec_c = mk(COND_ALWAYS, 0);
        send_word("post_rst", d, 4'd7, 8'h00, 64'd0);
        tick();
        check("post_rst_res", 64'({res_valid_o, r_s.exec_en}), 64'b11);
        check("post_rst_data0", r_s.self_data | r_s.other_data, 64'd0);
        tick();

`ifdef DISP_SEQ_TIMEOUT_EN
        // Watchdog: a read that is never granted.
        begin
            int n;
            d                   = '0;
            d.self_read_c       = mk(COND_ALWAYS, 0);
            d.exec_c            = mk(COND_ALWAYS, 0);
            send_word("wdog", d, 4'd2, 8'h00, 64'd0);
            n = 0;
            while (!err_o && n < 70000) begin
                tick();
                n++;
            end
            check("wdog_err_o", 64'(err_o), 64'd1);
            check("wdog_res", 64'({res_valid_o, r_s.err}), 64'b11);
            check("wdog_enables", 64'({r_s.del, r_s.sleep, r_s.fork_en, r_s.exec_en}), 64'd0);
            check("wdog_req_dropped", 64'(mem_req_o), 64'd0);
            tick();
            check("wdog_pulse", 64'(err_o), 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
